// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 16-bit multiplier that borrows the shared ALU.
// Ports: clk, rst_n, start/op_a/op_b in; busy/done/result/res_zero/
// res_pos out; alu_a/alu_b/alu_s drive the ALU, alu_o/alu_z/alu_g return.
module alu_mult_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        res_zero,
  output logic        res_pos,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_s,
  input  logic [15:0] alu_o,
  input  logic        alu_z,
  input  logic        alu_g
);

  localparam logic [1:0] S_ADD = 2'd0;
  localparam logic [1:0] S_SLL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] acc;
  logic [15:0] m;
  logic [15:0] q;

  logic        q_zero;
  logic        in_idle;
  logic        in_add;
  logic        in_shift;
  logic        in_fin;

  assign q_zero   = (q == 16'd0);
  assign in_idle  = (state == IDLE);
  assign in_add   = (state == ADD);
  assign in_shift = (state == SHIFT);
  assign in_fin   = (state == FIN);

  assign busy = !in_idle;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      in_idle:  if (start) state_nx = ADD;
      in_add:   state_nx = q_zero ? FIN : SHIFT;
      in_shift: state_nx = ADD;
      in_fin:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // ALU drive; FIN adds zero so the ALU
  // hands back acc together with its flags
  always_comb begin
    alu_s = S_ADD;
    alu_a = 16'd0;
    alu_b = 16'd0;
    unique case (1'b1)
      in_idle: begin
        alu_s = S_ADD;
      end
      in_add: begin
        if (!q_zero) begin
          alu_a = acc;
          alu_b = m;
        end
      end
      in_shift: begin
        alu_s = S_SLL;
        alu_a = m;
        alu_b = 16'd1;
      end
      in_fin: begin
        alu_a = acc;
      end
      default: begin
        alu_s = S_ADD;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      m   <= '0;
      q   <= '0;
    end else begin
      unique case (1'b1)
        in_idle: begin
          if (start) begin
            acc <= '0;
            m   <= op_a;
            q   <= op_b;
          end
        end
        in_add: begin
          if (!q_zero && q[0]) acc <= alu_o;
        end
        in_shift: begin
          m <= alu_o;
          q <= {1'b0, q[15:1]};
        end
        in_fin: begin
          acc <= acc;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  // result registers move only on the done edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      res_zero <= 1'b0;
      res_pos  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= in_fin;
      if (in_fin) begin
        result   <= alu_o;
        res_zero <= alu_z;
        res_pos  <= alu_g;
      end
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural ALU.
// Covers latency, wrap, signed, busy-start, done-start and reset abort.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        res_zero;
  logic        res_pos;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_s;
  logic [15:0] alu_o;
  logic        alu_z;
  logic        alu_g;

  int npass;
  int ntot;
  int bad_s;
  int s2_seen;
  int both_hi;
  int done_cnt;

  alu_mult_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .res_zero (res_zero),
    .res_pos  (res_pos),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_o    (alu_o),
    .alu_z    (alu_z),
    .alu_g    (alu_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference ALU: 0 add, 1 sub, 2 sll, 3 and
  always_comb begin
    alu_o = 16'd0;
    case (alu_s)
      2'd0: alu_o = alu_a + alu_b;
      2'd1: alu_o = alu_a - alu_b;
      2'd2: alu_o = alu_a << alu_b[3:0];
      2'd3: alu_o = alu_a & alu_b;
      default: alu_o = 16'd0;
    endcase
    alu_z = (alu_o == 16'd0);
    alu_g = ($signed(alu_o) > 16'sd0);
  end

  always @(negedge clk) begin
    if (alu_s == 2'd1 || alu_s == 2'd3) bad_s++;
    if (busy && alu_s == 2'd2) s2_seen++;
    if (busy && done) both_hi++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue a start, then count cycles to done;
  // inj=1 pulses a 7x7 start while busy
  task automatic run(input logic [15:0] a,
                     input logic [15:0] b,
                     input bit inj,
                     output int n);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    do begin
      if (inj && n == 3) begin
        op_a  = 16'd7;
        op_b  = 16'd7;
        start = 1'b1;
      end
      if (inj && n == 4) start = 1'b0;
      @(posedge clk);
      n++;
      #1;
      if (n == 1) check("busy_on", 32'(busy), 32'd1);
    end while (!done && n < 60);
    start = 1'b0;
  endtask

  task automatic expect_res(input string tag,
                            input int n, input int lat,
                            input logic [15:0] r,
                            input logic z, input logic p);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, 32'(result), 32'(r));
    check({tag, "_z"}, 32'(res_zero), 32'(z));
    check({tag, "_p"}, 32'(res_pos), 32'(p));
  endtask

  initial begin
    int n;
    npass    = 0;
    ntot     = 0;
    bad_s    = 0;
    s2_seen  = 0;
    both_hi  = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_z", 32'(res_zero), 32'd0);
    check("rst_p", 32'(res_pos), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(16'd3, 16'd5, 1'b0, n);
    expect_res("3x5", n, 8, 16'h000F, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("done_1cyc", 32'(done), 32'd0);

    s2_seen = 0;
    run(16'h1234, 16'h0000, 1'b0, n);
    expect_res("x0", n, 2, 16'h0000, 1'b1, 1'b0);
    check("x0_no_sll", 32'(s2_seen), 32'd0);

    run(16'hFFFF, 16'hFFFF, 1'b0, n);
    expect_res("ffxff", n, 34, 16'h0001, 1'b0, 1'b1);

    run(16'hFFFD, 16'd5, 1'b0, n);
    expect_res("m3x5", n, 8, 16'hFFF1, 1'b0, 1'b0);

    run(16'd3, 16'd5, 1'b1, n);
    expect_res("busy_st", n, 8, 16'h000F, 1'b0, 1'b1);
    // done is high now: a start here is accepted
    run(16'd7, 16'd7, 1'b0, n);
    expect_res("7x7", n, 8, 16'h0031, 1'b0, 1'b1);

    op_a  = 16'd3;
    op_b  = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_res", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) @(posedge clk);
    #1;
    check("ab_nodone", 32'(done_cnt), 32'd0);
    check("ab_idle", 32'(busy), 32'd0);

    check("alu_s_legal", 32'(bad_s), 32'd0);
    check("busy_done_excl", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
